mux_scan_n: RTL
===============

Name: mux_scan_n

Overview:
Parametrised, registered N:1 multiplexer that generalises the team's single-bit 2:1 select gate (z = sel ? b : a).
- Takes CHANNELS inputs, each WIDTH bits wide, and delivers the selected word through a valid/ready output register.
- Supports manual selection and an auto-scan mode that steps through every channel in turn.
- Sits between the lab stimulus sources and the result checker; in scan mode it serialises all channels to one checker.

Parameters:
WIDTH, 8, data bits per channel (>=1)
CHANNELS, 4, number of input channels (>=2, need not be a power of 2)
DWELL, 2, accepted transfers per channel before scan advances (>=1)
SEL_W, $clog2(CHANNELS), select width (derived localparam, not overridable)

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  synchronous active-low reset
in_data  in  CHANNELS*WIDTH  channel k occupies bits [k*WIDTH +: WIDTH]
mode  in  1  0 = manual select, 1 = auto-scan
sel  in  SEL_W  manual channel select (ignored in scan)
in_valid  in  1  upstream word available
in_ready  out  1  block can accept this cycle
out_data  out  WIDTH  registered selected word
out_sel  out  SEL_W  channel index that produced out_data
out_valid  out  1  out_data/out_sel valid
out_ready  in  1  downstream accepts
sel_err  out  1  registered; high with a word whose manual sel was >= CHANNELS
scan_wrap  out  1  one-cycle pulse, see below

Behaviour:
- Reset: sampled only on a rising clk edge with rst_n=0. All outputs except in_ready are 0 after reset: out_data, out_sel, out_valid, sel_err, scan_wrap. in_ready is combinational and therefore 1. Internal state is also cleared: scan index, dwell count and FSM, which returns to MANUAL. Reset mid-transfer drops any held word without emitting it.
- Handshake: in_ready = !out_valid || out_ready (combinational, single-stage pipeline register).
- Accept: in_valid && in_ready. The register loads on that edge, so latency is 1 cycle from accept to out_valid.
- out_valid holds, with out_data/out_sel/sel_err stable, until out_valid && out_ready.
- Simultaneous drain and accept in the same cycle: the new word replaces the old and out_valid stays 1. No bubble at full throughput.
- If out_ready=1 and there is no accept, out_valid clears on the next edge.
- Effective select: manual uses sel; scan uses the internal scan index.
- Manual sel >= CHANNELS: out_data=0, out_sel=sel, sel_err=1 for that word. The transfer still completes and no state is corrupted.
- FSM states:
  - MANUAL: entered from reset, or from SCAN when mode=0.
  - SCAN: entered when mode=1.
  - mode is sampled every cycle. On a MANUAL->SCAN transition, scan index and dwell count are set to 0, so the first scanned word comes from channel 0.
  - A mode change takes effect for accepts starting the cycle after mode changes. The word accepted in the same cycle uses the previous state.
- Scan progression: only accepted transfers count; stalls and idle cycles do not advance.
  - After DWELL accepts on index i, the index becomes i+1.
  - From CHANNELS-1 the index wraps to 0 and scan_wrap pulses high for exactly one cycle. The pulse is coincident with out_valid rising for the last word of the final channel, i.e. the cycle that word is registered.
  - Non-power-of-2 CHANNELS: the index never reaches CHANNELS; it wraps explicitly.
- Width rules: in_data is sliced with an indexed part-select. No arithmetic is done on data. The dwell counter is $clog2(DWELL+1) bits.

Test Plan:
1. Manual, WIDTH=8, CHANNELS=4, in_data={8'hD4,8'hC3,8'hB2,8'hA1}, sel=2, single accept, out_ready=1 -> one cycle later out_valid=1, out_data=8'hB2, out_sel=2, sel_err=0; next cycle out_valid=0.
2. Backpressure: out_ready=0 for 3 cycles after first accept with in_valid held -> in_ready=0, out_data frozen at first word. Release out_ready -> back-to-back transfers with no bubble.
3. Scan, DWELL=2, continuous in_valid/out_ready, 8 accepts -> out_sel sequence 0,0,1,1,2,2,3,3; scan_wrap=1 only with the 8th word; 9th word out_sel=0.
4. CHANNELS=3, manual sel=3 -> out_data=0, sel_err=1, out_sel=3. Then sel=1 -> correct word, sel_err=0.
5. Scan interrupted: after 3 scanned accepts switch mode=0 then mode=1 -> next scanned word out_sel=0.
6. Reset mid-operation: assert rst_n=0 for one edge while out_valid=1 and out_ready=0 -> out_valid=0, scan_wrap=0, in_ready=1. Next scan restarts at channel 0.

Source files
------------

// File: rtl/mux_scan_n.sv
// rtl/mux_scan_n.sv - registered N:1 word multiplexer with manual select and auto-scan
module mux_scan_n #(
    parameter int  WIDTH    = 8,
    parameter int  CHANNELS = 4,
    parameter int  DWELL    = 2,
    localparam int SEL_W    = $clog2(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    input  logic                      mode,
    input  logic [SEL_W-1:0]          sel,
    input  logic                      in_valid,
    output logic                      in_ready,
    output logic [WIDTH-1:0]          out_data,
    output logic [SEL_W-1:0]          out_sel,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic                      sel_err,
    output logic                      scan_wrap
);

    localparam int                CNT_W      = $clog2(DWELL + 1);
    localparam logic [CNT_W-1:0]  DWELL_LAST = CNT_W'(DWELL - 1);
    localparam logic [SEL_W-1:0]  IDX_LAST   = SEL_W'(CHANNELS - 1);

    typedef enum logic {MANUAL, SCAN} state_t;

    state_t             state;
    state_t             state_next;
    logic               scan_active;
    logic [SEL_W-1:0]   eff_sel;
    logic               sel_bad;
    logic [SEL_W-1:0]   scan_idx;
    logic [CNT_W-1:0]   dwell_cnt;
    logic               accept;
    logic               dwell_done;
    logic               idx_last;

    assign in_ready   = !out_valid || out_ready;
    assign accept     = in_valid && in_ready;
    assign dwell_done = (dwell_cnt == DWELL_LAST);
    assign idx_last   = (scan_idx == IDX_LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= MANUAL;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            MANUAL:  if (mode)  state_next = SCAN;
            SCAN:    if (!mode) state_next = MANUAL;
            default: state_next = MANUAL;
        endcase
    end

    // The select follows the registered state, so a mode change only affects later accepts.
    always_comb begin
        scan_active = (state == SCAN);
        eff_sel     = scan_active ? scan_idx : sel;
        sel_bad     = !scan_active && (32'(sel) >= CHANNELS);
    end

    // Index and dwell stay cleared while in MANUAL, so every scan entry starts at channel 0.
    always_ff @(posedge clk) begin
        if (!rst_n || !scan_active) begin
            scan_idx  <= '0;
            dwell_cnt <= '0;
        end else if (accept) begin
            if (dwell_done) begin
                dwell_cnt <= '0;
                scan_idx  <= idx_last ? '0 : scan_idx + 1'b1;
            end else begin
                dwell_cnt <= dwell_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_data  <= '0;
            out_sel   <= '0;
            out_valid <= 1'b0;
            sel_err   <= 1'b0;
            scan_wrap <= 1'b0;
        end else begin
            scan_wrap <= accept && scan_active && dwell_done && idx_last;
            if (accept) begin
                out_data  <= sel_bad ? '0 : in_data[eff_sel*WIDTH +: WIDTH];
                out_sel   <= eff_sel;
                sel_err   <= sel_bad;
                out_valid <= 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule
